// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master, one-slave bus arbiter.
// m0 (hart) and m1 (debug system-bus access) share a single slave port.
// m1 has priority, but m0 is guaranteed a grant after StarveLimit
// consecutive m1 grants that it waited through. Slave accesses that get
// no s_done within TimeoutCycles are aborted with a fault to the owner.
// All outputs are registered.
module bus_arbiter #(
    parameter int unsigned TimeoutCycles = 255,
    parameter int unsigned StarveLimit   = 4
) (
    input  logic        clk,
    input  logic        rst,

    // master 0 (hart)
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [2:0]  m0_size,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_done,
    output logic        m0_fault,

    // master 1 (debug system-bus access)
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [2:0]  m1_size,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_done,
    output logic        m1_fault,

    // shared slave port
    output logic        s_req,
    output logic        s_we,
    output logic [31:0] s_addr,
    output logic [2:0]  s_size,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_done,
    input  logic        s_fault,

    // status
    output logic        busy,
    output logic        owner
);

    // Timeout counter must be able to hold TimeoutCycles itself.
    localparam int unsigned CntW =
        (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] TimeoutVal = CntW'(TimeoutCycles);
    localparam logic [2:0]      StarveMax  = 3'(StarveLimit);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state_q;
    logic [CntW-1:0] tmo_cnt_q;
    logic [2:0]      starve_q;
    logic            owner_q;
    logic            busy_q;

    logic            s_req_q;
    logic            s_we_q;
    logic [31:0]     s_addr_q;
    logic [2:0]      s_size_q;
    logic [31:0]     s_wdata_q;

    logic [31:0]     m0_rdata_q;
    logic            m0_done_q;
    logic            m0_fault_q;
    logic [31:0]     m1_rdata_q;
    logic            m1_done_q;
    logic            m1_fault_q;

    // Arbitration decision, only acted on in IDLE.
    logic            any_req_d;
    logic            grant_m1_d;
    logic            starve_hit_d;
    logic [2:0]      starve_d;
    logic            tmo_hit_d;

    // Grant selection and starvation counter next value.
    always_comb begin
        any_req_d    = m0_req | m1_req;
        starve_hit_d = (starve_q == StarveMax);
        grant_m1_d   = m1_req & (~m0_req | ~starve_hit_d);
        starve_d     = starve_q;
        if (grant_m1_d) begin
            if (m0_req) begin
                if (!starve_hit_d) begin
                    starve_d = starve_q + 3'd1;
                end
            end else begin
                starve_d = '0;
            end
        end else begin
            starve_d = '0;
        end
        tmo_hit_d    = (tmo_cnt_q == TimeoutVal);
    end

    // Main FSM with registered slave-side and master-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tmo_cnt_q  <= '0;
            starve_q   <= '0;
            owner_q    <= 1'b0;
            busy_q     <= 1'b0;
            s_req_q    <= 1'b0;
            s_we_q     <= 1'b0;
            s_addr_q   <= '0;
            s_size_q   <= '0;
            s_wdata_q  <= '0;
            m0_rdata_q <= '0;
            m0_done_q  <= 1'b0;
            m0_fault_q <= 1'b0;
            m1_rdata_q <= '0;
            m1_done_q  <= 1'b0;
            m1_fault_q <= 1'b0;
        end else begin
            // Pulses default low; each is raised for exactly one cycle.
            s_req_q   <= 1'b0;
            m0_done_q <= 1'b0;
            m1_done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (any_req_d) begin
                        owner_q  <= grant_m1_d;
                        starve_q <= starve_d;
                        if (grant_m1_d) begin
                            s_we_q    <= m1_we;
                            s_addr_q  <= m1_addr;
                            s_size_q  <= m1_size;
                            s_wdata_q <= m1_wdata;
                        end else begin
                            s_we_q    <= m0_we;
                            s_addr_q  <= m0_addr;
                            s_size_q  <= m0_size;
                            s_wdata_q <= m0_wdata;
                        end
                        s_req_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end

                ISSUE: begin
                    tmo_cnt_q <= '0;
                    state_q   <= WAIT;
                end

                WAIT: begin
                    // s_done has priority over a coincident timeout.
                    if (s_done) begin
                        if (owner_q) begin
                            m1_rdata_q <= s_rdata;
                            m1_fault_q <= s_fault;
                            m1_done_q  <= 1'b1;
                        end else begin
                            m0_rdata_q <= s_rdata;
                            m0_fault_q <= s_fault;
                            m0_done_q  <= 1'b1;
                        end
                        state_q <= RESP;
                    end else if (tmo_hit_d) begin
                        if (owner_q) begin
                            m1_fault_q <= 1'b1;
                            m1_done_q  <= 1'b1;
                        end else begin
                            m0_fault_q <= 1'b1;
                            m0_done_q  <= 1'b1;
                        end
                        state_q <= RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end

                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s_req    = s_req_q;
    assign s_we     = s_we_q;
    assign s_addr   = s_addr_q;
    assign s_size   = s_size_q;
    assign s_wdata  = s_wdata_q;
    assign m0_rdata = m0_rdata_q;
    assign m0_done  = m0_done_q;
    assign m0_fault = m0_fault_q;
    assign m1_rdata = m1_rdata_q;
    assign m1_done  = m1_done_q;
    assign m1_fault = m1_fault_q;
    assign busy     = busy_q;
    assign owner    = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed bench for bus_arbiter (TimeoutCycles = 8).
module tb_bus_arbiter;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [2:0]  m0_size, m1_size;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_done, m0_fault, m1_done, m1_fault;
    logic        s_req, s_we;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [2:0]  s_size;
    logic        s_done, s_fault;
    logic        busy, owner;

    int vectors     = 0;
    int miscompares = 0;

    bus_arbiter #(
        .TimeoutCycles(TMO),
        .StarveLimit  (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m0_req  (m0_req),
        .m0_we   (m0_we),
        .m0_addr (m0_addr),
        .m0_size (m0_size),
        .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata),
        .m0_done (m0_done),
        .m0_fault(m0_fault),
        .m1_req  (m1_req),
        .m1_we   (m1_we),
        .m1_addr (m1_addr),
        .m1_size (m1_size),
        .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata),
        .m1_done (m1_done),
        .m1_fault(m1_fault),
        .s_req   (s_req),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_size  (s_size),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata),
        .s_done  (s_done),
        .s_fault (s_fault),
        .busy    (busy),
        .owner   (owner)
    );

    always #5 clk = ~clk;

    // advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic exp_own [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_size = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_size = '0; m1_wdata = '0;
        s_rdata = '0; s_done = 0; s_fault = 0;

        // ---- reset state
        step(); step();
        chk("rst_s_req",   s_req,    0);
        chk("rst_busy",    busy,     0);
        chk("rst_owner",   owner,    0);
        chk("rst_m0_done", m0_done,  0);
        chk("rst_m1_done", m1_done,  0);
        chk("rst_m0_rd",   m0_rdata, 0);
        chk("rst_s_addr",  s_addr,   0);
        rst = 1'b0;
        step();

        // ---- m0 read alone, slave answers after 3 wait cycles
        m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0100; m0_size = 3'b010;
        step();                                   // ISSUE
        chk("rd_s_req",   s_req,  1);
        chk("rd_s_addr",  s_addr, 32'h0000_0100);
        chk("rd_s_size",  s_size, 32'd2);
        chk("rd_s_we",    s_we,   0);
        chk("rd_busy",    busy,   1);
        chk("rd_owner",   owner,  0);
        step();                                   // WAIT 1
        chk("rd_s_req_w", s_req,  0);
        step(); step();                           // WAIT 2,3
        chk("rd_nodone",  m0_done, 0);
        s_done = 1; s_rdata = 32'hDEAD_BEEF;
        step();                                   // RESP
        s_done = 0; m0_req = 0;
        chk("rd_done",    m0_done,  1);
        chk("rd_m1_done", m1_done,  0);
        chk("rd_rdata",   m0_rdata, 32'hDEAD_BEEF);
        chk("rd_fault",   m0_fault, 0);
        step();                                   // IDLE
        chk("rd_done_lo", m0_done,  0);
        chk("rd_busy_lo", busy,     0);
        chk("rd_hold",    m0_rdata, 32'hDEAD_BEEF);

        // ---- both masters held, instant slave: m1 x4, m0, m1
        m0_addr = 32'h0000_1000; m1_addr = 32'h0000_2000;
        m0_req = 1; m1_req = 1; s_done = 1;
        for (int i = 0; i < 6; i++) begin
            s_rdata = 32'h1111_0000 + 32'(i);
            step();                               // ISSUE
            chk("arb_s_req", s_req, 1);
            chk("arb_owner", owner, exp_own[i]);
            chk("arb_addr",  s_addr, exp_own[i] ? 32'h0000_2000 : 32'h0000_1000);
            step();                               // WAIT
            step();                               // RESP
            chk("arb_m0_done", m0_done, exp_own[i] ? 1'b0 : 1'b1);
            chk("arb_m1_done", m1_done, exp_own[i] ? 1'b1 : 1'b0);
            chk("arb_rdata", exp_own[i] ? m1_rdata : m0_rdata, 32'h1111_0000 + 32'(i));
            step();                               // IDLE
            chk("arb_gap", s_req, 0);
        end
        m0_req = 0; m1_req = 0; s_done = 0;

        // ---- m1 write, slave silent -> timeout fault
        m1_req = 1; m1_we = 1; m1_addr = 32'h0000_3000; m1_wdata = 32'hCAFE_F00D;
        m1_size = 3'b010;
        step();                                   // ISSUE at cycle S
        chk("to_s_req",   s_req,   1);
        chk("to_s_we",    s_we,    1);
        chk("to_s_wdata", s_wdata, 32'hCAFE_F00D);
        chk("to_owner",   owner,   1);
        for (int k = 1; k <= int'(TMO) + 1; k++) begin
            step();
            chk("to_nodone", m1_done, 0);
        end
        step();                                   // S + TMO + 2
        m1_req = 0;
        chk("to_done",  m1_done,  1);
        chk("to_fault", m1_fault, 1);
        chk("to_rdata", m1_rdata, 32'h1111_0005);
        step();
        chk("to_done_lo", m1_done, 0);
        s_done = 1; s_rdata = 32'h0000_0BAD;      // late response
        step();
        s_done = 0;
        chk("late_done", m1_done,  0);
        chk("late_busy", busy,     0);
        chk("late_rd",   m1_rdata, 32'h1111_0005);
        step();
        chk("late_done2", m1_done, 0);

        // ---- s_done coincides with timeout, s_fault = 0
        m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0400;
        step();                                   // ISSUE at S
        for (int k = 1; k <= int'(TMO); k++) step();
        step();                                   // S + TMO + 1: counter at limit
        s_done = 1; s_fault = 0; s_rdata = 32'h1234_5678;
        step();
        s_done = 0; m0_req = 0;
        chk("tie_done",  m0_done,  1);
        chk("tie_fault", m0_fault, 0);
        chk("tie_rdata", m0_rdata, 32'h1234_5678);
        step();

        // ---- reset while waiting
        m1_req = 1; m1_we = 0; m1_addr = 32'h0000_0500;
        step();                                   // ISSUE
        step(); step();                           // WAIT
        rst = 1;
        #1;
        chk("mr_busy",  busy,     0);
        chk("mr_owner", owner,    0);
        chk("mr_s_adr", s_addr,   0);
        chk("mr_rd",    m1_rdata, 0);
        chk("mr_flt",   m1_fault, 0);
        step();
        rst = 0; m1_req = 0;
        s_done = 1; s_rdata = 32'h0000_0077;
        step();
        s_done = 0;
        chk("mr_nodone", m1_done, 0);
        chk("mr_busy2",  busy,    0);
        step();
        chk("mr_nodone2", m1_done, 0);
        m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0600;
        step();                                   // ISSUE
        chk("mr_arb_req",  s_req,  1);
        chk("mr_arb_own",  owner,  0);
        chk("mr_arb_addr", s_addr, 32'h0000_0600);

        // ---- owner drops req during WAIT
        step();                                   // WAIT
        m0_req = 0; m0_addr = 32'h0000_FFFF;
        step();
        chk("drop_addr_w", s_addr, 32'h0000_0600);
        s_done = 1; s_rdata = 32'h0000_A5A5;
        step();                                   // RESP
        s_done = 0;
        chk("drop_done",   m0_done,  1);
        chk("drop_addr_r", s_addr,   32'h0000_0600);
        chk("drop_rdata",  m0_rdata, 32'h0000_A5A5);
        step();
        chk("drop_done_lo", m0_done, 0);
        chk("drop_busy",    busy,    0);
        step();
        chk("drop_once",  m0_done, 0);
        chk("drop_noreq", s_req,   0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TimeoutCycles, default 255: number of cycles without s_done before a slave transaction is aborted with a fault.
REQ-002 Parameter StarveLimit, default 4: number of consecutive m1 grants allowed while m0 waits before m0 is forced a grant.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 m0_req, m1_req  in  1 each  master request; held with its fields stable until that master's done pulse (m0 = hart, m1 = debug system-bus access).
REQ-006 m0_we, m1_we  in  1 each  1 = write, 0 = read.
REQ-007 m0_addr, m1_addr  in  32 each  byte address.
REQ-008 m0_size, m1_size  in  3 each  sign/size code, passed through unmodified.
REQ-009 m0_wdata, m1_wdata  in  32 each  write data.
REQ-010 m0_rdata, m1_rdata  out  32 each  registered read data, valid with done.
REQ-011 m0_done, m1_done  out  1 each  one-cycle completion pulse.
REQ-012 m0_fault, m1_fault  out  1 each  fault flag, valid only with done.
REQ-013 s_req  out  1  one-cycle start pulse to the shared bus port.
REQ-014 s_we, s_addr, s_size, s_wdata  out  1/32/3/32  registered copy of the granted master's fields.
REQ-015 s_rdata  in  32  slave read data, valid with s_done.
REQ-016 s_done, s_fault  in  1 each  slave completion pulse and fault.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 owner  out  1  0 = m0, 1 = m1; last granted master.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-020 In IDLE, arbitration occurs every cycle: with a single requester, that requester is granted; with both requesting, m1 is granted unless starve_cnt == StarveLimit, in which case m0 is granted.
REQ-021 On grant, the block registers owner and the granted fields into s_we/s_addr/s_size/s_wdata and moves to ISSUE.
REQ-022 ISSUE lasts one cycle with s_req = 1, clears the timeout counter and moves to WAIT.
REQ-023 In WAIT, s_req = 0 and s fields are held; the timeout counter increments every cycle.
REQ-024 When s_done = 1 in WAIT, the block captures s_rdata and s_fault into the owner's rdata/fault registers and moves to RESP.
REQ-025 When the counter reaches TimeoutCycles without s_done, the block sets the owner's fault = 1, leaves its rdata unchanged and moves to RESP.
REQ-026 If s_done and timeout occur in the same cycle, s_done wins and fault = s_fault.
REQ-027 RESP lasts one cycle: the owner's done = 1, the other master's done = 0, then the block moves to IDLE.
REQ-028 Latency is fixed: a request sampled in IDLE at cycle N gives s_req at N+1; s_done at cycle M gives master done at M+1; the minimum gap between consecutive s_req pulses is 4 cycles.
REQ-029 starve_cnt is 3 bits wide and saturates at StarveLimit.
REQ-030 starve_cnt increments on an m1 grant while m0_req = 1, clears on any m0 grant, and clears on an m1 grant while m0_req = 0.
REQ-031 Outside WAIT, s_done/s_fault are ignored; a late s_done after timeout produces no done pulse.
REQ-032 If the owner drops its req before done, the transaction still completes and done still pulses once.
REQ-033 A master's req sampled on its own done cycle is not a new request; re-arbitration starts in IDLE.
REQ-034 rdata/fault registers hold their values until the next completion for that master.

Reset
REQ-035 While rst = 1 (asynchronous), the block enters IDLE and forces s_req = 0, all done = 0, all fault = 0, busy = 0, owner = 0, starve_cnt = 0, timeout counter = 0, all rdata = 0 and all s fields = 0.
REQ-036 Reset mid-transaction abandons the outstanding slave access, and no done is issued for it after reset release.

Verification
REQ-037 m0 read of 0x0000_0100 alone, slave returns 0xDEADBEEF after 3 cycles -> s_req 1 cycle after sample, m0_done 1 cycle after s_done, m0_rdata = 0xDEADBEEF, m0_fault = 0.
REQ-038 m0 and m1 request together, both held continuously, instant slave -> grant order m1,m1,m1,m1,m0,m1,... with owner tracking each grant.
REQ-039 m1 write, slave never responds -> m1_done with m1_fault = 1 exactly TimeoutCycles+2 cycles after s_req; a later s_done is ignored.
REQ-040 s_done and timeout in the same cycle with s_fault = 0 -> done with fault = 0.
REQ-041 rst asserted in WAIT, then s_done arrives after release -> no done pulse, busy = 0, next request arbitrates normally.
REQ-042 Owner drops req in WAIT -> done still pulses once and s fields are stable until RESP.
